// File: rtl/sop_event_unit.sv
// Two-stage sum-of-products reduction pipeline with valid/ready handshakes,
// plus an independent trigger-capture path (edge-of-level events on trig).
module sop_event_unit #(
    parameter int W    = 8,
    parameter int NCH  = 2,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*W-1:0]  op_a,
    input  logic [NCH*W-1:0]  op_b,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      y,
    output logic              err,
    input  logic              trig,
    input  logic [W-1:0]      cap_d,
    output logic [W-1:0]      kid,
    output logic              kid_stb,
    output logic [CNTW-1:0]   cap_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid holds its payload until that edge.
    logic              s1_valid_q, s1_valid_d;
    logic [NCH*W-1:0]  s1_terms_q, s1_terms_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic              s2_valid_q, s2_valid_d;
    logic [W-1:0]      y_q, y_d;
    logic              err_q, err_d;
    logic              trig_q;
    logic [W-1:0]      kid_q, kid_d;
    logic              kid_stb_q, kid_stb_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic              s1_adv, s2_adv;
    logic [NCH*W-1:0]  terms;
    logic [W-1:0]      red;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;

    always_comb begin
        terms = '0;
        for (int k = 0; k < NCH; k++) begin
            case (mode)
                2'd0:    terms[k*W +: W] = op_a[k*W +: W] & op_b[k*W +: W];
                2'd1:    terms[k*W +: W] = op_a[k*W +: W] ^ op_b[k*W +: W];
                2'd2:    terms[k*W +: W] = op_a[k*W +: W] | op_b[k*W +: W];
                default: terms[k*W +: W] = '0;
            endcase
        end
    end

    // Reduction identity is all-ones for AND, zero for OR/XOR and reserved mode.
    always_comb begin
        red = (s1_mode_q == 2'd2) ? '1 : '0;
        for (int k = 0; k < NCH; k++) begin
            case (s1_mode_q)
                2'd0:    red = red | s1_terms_q[k*W +: W];
                2'd1:    red = red ^ s1_terms_q[k*W +: W];
                2'd2:    red = red & s1_terms_q[k*W +: W];
                default: red = '0;
            endcase
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_terms_d = s1_terms_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        err_d      = err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d   = red;
                err_d = (s1_mode_q == 2'd3);
            end
        end
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_terms_d = terms;
                s1_mode_d  = mode;
            end
        end
    end

    always_comb begin
        kid_d     = kid_q;
        kid_stb_d = 1'b0;
        cnt_d     = cnt_q;
        if (trig != trig_q) begin
            kid_d     = cap_d;
            kid_stb_d = 1'b1;
            cnt_d     = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_terms_q <= '0;
            s1_mode_q  <= 2'd0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            err_q      <= 1'b0;
            trig_q     <= trig;
            kid_q      <= '0;
            kid_stb_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_terms_q <= s1_terms_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            err_q      <= err_d;
            trig_q     <= trig;
            kid_q      <= kid_d;
            kid_stb_q  <= kid_stb_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign err       = err_q;
    assign kid       = kid_q;
    assign kid_stb   = kid_stb_q;
    assign cap_cnt   = cnt_q;

endmodule
